fir_mac_scheduler: RTL and testbench
====================================

# fir_mac_scheduler

Time-multiplexed FIR controller for the AM-demodulator path. It accepts ADC samples over a valid/ready handshake and optionally squares each sample for envelope detection. It stores samples in a circular delay line and drives one shared multiplier-accumulator through all taps per output, with optional decimation. Its output is a saturated signed word for the DAC.

## Interface
- TAPS, 32: filter length; power of two, ≥4.
- DW, 8: ADC sample width (offset binary).
- CW, 12: signed coefficient width.
- OW, 14: signed output width.
- SHIFT, 15: right shift applied to the accumulator before saturation; ≥1.
- DECIM, 1: one output per DECIM accepted samples; ≥1.
- COEF_FILE, "fir_coef.mif": coefficient init file for the ROM.
- sys_clk  in  1  single clock, all logic rising-edge.
- sys_rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  in_data valid.
- in_data  in  DW  ADC sample.
- in_ready  out  1  block can accept a sample.
- out_valid  out  1  one-cycle pulse, out_data updated.
- out_data  out  OW  filter output, signed, held between pulses.

## Operation
- Sample conversion: invert the in_data MSB to get signed s. Squared mode gives x = s*s, 2*DW bits. Linear mode gives x = s sign-extended to 2*DW bits.
- Delay line: TAPS x 2*DW RAM with synchronous read. wr_ptr is log2(TAPS) bits and wraps TAPS-1 → 0. Tap k reads address wr_ptr-k mod TAPS.
- Accumulator width: ACCW = 2*DW+CW+log2(TAPS)+1, signed. It never overflows.
- Output: (acc + 2^(SHIFT-1)) >>> SHIFT, saturated to [-2^(OW-1), 2^(OW-1)-1].
- Decimation counter dcnt runs 0..DECIM-1 and increments on every accepted sample. A MAC run happens only when dcnt == DECIM-1; dcnt then wraps to 0.
- State machine:
  - CLEAR: entered from reset. Writes zero to all TAPS buffer entries, one per cycle. Then IDLE.
  - IDLE: in_ready=1. On in_valid, latch x, go to LOAD.
  - LOAD: write x at wr_ptr and clear acc. Go to MAC if a run is due; otherwise advance wr_ptr and go to IDLE.
  - MAC: issue read tap k = 0..TAPS-1, one per cycle, with coefficient address k. The product is registered and accumulated with 2 cycles of pipeline lag. After k = TAPS-1, go to DRAIN.
  - DRAIN: 2 cycles, flushing the pipeline. Then DONE.
  - DONE: register the rounded and saturated result into out_data, pulse out_valid, advance wr_ptr, go to IDLE.
- in_ready is 1 only in IDLE. in_valid outside IDLE is ignored. Upstream holds the sample.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, acc=0, wr_ptr=0, dcnt=0, state CLEAR.
- in_ready first rises TAPS cycles after sys_rst deasserts.
- Latency: out_valid occurs TAPS+4 cycles after the accepting edge (1 LOAD + TAPS MAC + 2 DRAIN + 1 DONE). That is 36 cycles at the default.
- Throughput: a run-triggering sample costs TAPS+5 cycles including IDLE. A non-run sample costs 2 cycles.
- A simultaneous in_valid with the DONE→IDLE transition is accepted on the following (IDLE) cycle.
- Reset mid-operation aborts immediately: outputs return to reset values, the buffer is re-cleared via CLEAR, and any partial result is discarded.
- Coefficient ROM and buffer reads are both 1-cycle synchronous and stay aligned.

## Configuration
- FIR_SQUARE_EN defined: input path is squared (x = s*s, non-negative). Use this for the AM envelope detector.
- FIR_SQUARE_EN undefined: linear FIR, x = sign-extended s, and no multiplier in the input path.
- Neither setting changes the state machine or the latency.

## Structure
- Package fir_sched_pkg holds:
  - the state enum (CLEAR, IDLE, LOAD, MAC, DRAIN, DONE);
  - localparam helpers for ACCW and the pointer width;
  - the saturate/round function.
- Sub-module fir_coef_rom: TAPS x CW synchronous ROM initialised from COEF_FILE. It is the only sub-module.

## Test plan
- Reset/clear: release sys_rst → in_ready=0 for exactly 32 cycles, then 1. out_valid stays 0 and out_data=0.
- Impulse, linear (macro off, SHIFT=1, DECIM=1): feed 0x81 (+1), then 0x80 (0) repeatedly → output n is round(coef[n]/2). Each out_valid comes exactly 36 cycles after its accept.
- Squared (macro on, SHIFT=15): feed 0x00 (s=-128, x=16384), then 0x80 → output n = round(coef[n]*16384/32768) = round(coef[n]/2).
- Saturation (macro on, SHIFT=1, all coef=2047): constant 0x00 input → out_data=8191. With coef=-2048 → -8192.
- Decimation (DECIM=4): 8 accepted samples → exactly 2 out_valid pulses, following the 4th and 8th accepts. Non-run samples have in_ready low for 1 cycle.
- Handshake/reset: hold in_valid=1 continuously → one accept per run, and in_ready is never high during MAC. Assert sys_rst at MAC tap 10 → no out_valid, and CLEAR repeats for 32 cycles.

Source files
------------

// File: rtl/fir_sched_pkg.sv
// rtl/fir_sched_pkg.sv - shared types and helpers for the FIR MAC scheduler
package fir_sched_pkg;

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    LOAD,
    MAC,
    DRAIN,
    DONE
  } state_e;

  function automatic int ptr_width(input int taps);
    return $clog2(taps);
  endfunction

  // Worst-case sum of TAPS full-scale products plus a sign bit, so no overflow.
  function automatic int acc_width(input int dw, input int cw, input int taps);
    return 2 * dw + cw + $clog2(taps) + 1;
  endfunction

  // Round half-up, arithmetic shift, then clamp to a signed ow-bit range.
  function automatic logic signed [31:0] round_sat(input logic signed [63:0] acc,
                                                   input int shift, input int ow);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r  = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    if (r > hi) r = hi;
    else if (r < lo) r = lo;
    return r[31:0];
  endfunction

endpackage

// File: rtl/fir_coef_rom.sv
// rtl/fir_coef_rom.sv - TAPS x CW coefficient ROM with one-cycle registered read
module fir_coef_rom #(
  parameter int TAPS = 32,
  parameter int CW   = 12,
  parameter logic [TAPS*CW-1:0] COEF = {TAPS{CW'((2 ** (CW - 1) - 1) / TAPS)}}
) (
  input  logic                      clk_i,
  input  logic [$clog2(TAPS)-1:0]   addr_i,
  output logic signed [CW-1:0]      data_o
);

  logic signed [CW-1:0] data_q;

  always_ff @(posedge clk_i) begin
    data_q <= COEF[addr_i*CW +: CW];
  end

  assign data_o = data_q;

endmodule

// File: rtl/fir_mac_scheduler.sv
// rtl/fir_mac_scheduler.sv - time-multiplexed FIR controller driving one shared MAC
// Define FIR_SQUARE_EN to square each input sample for envelope detection.
module fir_mac_scheduler
  import fir_sched_pkg::*;
#(
  parameter int TAPS  = 32,
  parameter int DW    = 8,
  parameter int CW    = 12,
  parameter int OW    = 14,
  parameter int SHIFT = 15,
  parameter int DECIM = 1,
  parameter logic [TAPS*CW-1:0] COEF = {TAPS{CW'((2 ** (CW - 1) - 1) / TAPS)}}
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 in_valid,
  input  logic [DW-1:0]        in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic signed [OW-1:0] out_data
);

  localparam int PW    = ptr_width(TAPS);
  localparam int ACCW  = acc_width(DW, CW, TAPS);
  localparam int XW    = 2 * DW;
  localparam int PRODW = XW + CW;
  localparam int DCW   = (DECIM > 1) ? $clog2(DECIM) : 1;

  state_e                  state_q, state_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           k_q, k_d;
  logic [DCW-1:0]          dcnt_q, dcnt_d;
  logic signed [XW-1:0]    x_q, x_d;
  logic signed [ACCW-1:0]  acc_q, acc_d;
  logic signed [PRODW-1:0] prod_q;
  logic                    rd_v_q, prod_v_q;
  logic                    out_valid_q, out_valid_d;
  logic signed [OW-1:0]    out_data_q, out_data_d;

  logic [XW-1:0]           mem [TAPS];
  logic signed [XW-1:0]    rd_data_q;
  logic signed [CW-1:0]    coef;
  logic                    mem_we;
  logic [PW-1:0]           mem_waddr;
  logic [XW-1:0]           mem_wdata;
  logic [PW-1:0]           rd_addr;
  logic signed [DW-1:0]    s;
  logic signed [XW-1:0]    x_conv;
  logic                    run_due;

  // Offset binary to two's complement is a flip of the MSB.
  assign s = {~in_data[DW-1], in_data[DW-2:0]};

`ifdef FIR_SQUARE_EN
  assign x_conv = XW'(s) * XW'(s);
`else
  assign x_conv = XW'(s);
`endif

  assign rd_addr  = wr_ptr_q - k_q;
  assign run_due  = (dcnt_q == DCW'(DECIM - 1));
  assign in_ready = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  fir_coef_rom #(
    .TAPS (TAPS),
    .CW   (CW),
    .COEF (COEF)
  ) u_coef_rom (
    .clk_i  (sys_clk),
    .addr_i (k_q),
    .data_o (coef)
  );

  always_ff @(posedge sys_clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    rd_data_q <= mem[rd_addr];
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= CLEAR;
      wr_ptr_q    <= '0;
      k_q         <= '0;
      dcnt_q      <= '0;
      x_q         <= '0;
      acc_q       <= '0;
      prod_q      <= '0;
      rd_v_q      <= 1'b0;
      prod_v_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      k_q         <= k_d;
      dcnt_q      <= dcnt_d;
      x_q         <= x_d;
      acc_q       <= acc_d;
      prod_q      <= PRODW'(rd_data_q) * PRODW'(coef);
      rd_v_q      <= (state_q == MAC);
      prod_v_q    <= rd_v_q;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    k_d         = k_q;
    dcnt_d      = dcnt_q;
    x_d         = x_q;
    acc_d       = acc_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    mem_we      = 1'b0;
    mem_waddr   = wr_ptr_q;
    mem_wdata   = x_q;

    // Products land two cycles after their read was issued.
    if (prod_v_q) acc_d = acc_q + ACCW'(prod_q);

    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = k_q;
        mem_wdata = '0;
        k_d       = k_q + PW'(1);
        if (k_q == PW'(TAPS - 1)) state_d = IDLE;
      end
      IDLE: begin
        if (in_valid) begin
          x_d     = x_conv;
          state_d = LOAD;
        end
      end
      LOAD: begin
        mem_we = 1'b1;
        acc_d  = '0;
        k_d    = '0;
        if (run_due) begin
          dcnt_d  = '0;
          state_d = MAC;
        end else begin
          dcnt_d   = dcnt_q + DCW'(1);
          wr_ptr_d = wr_ptr_q + PW'(1);
          state_d  = IDLE;
        end
      end
      MAC: begin
        k_d = k_q + PW'(1);
        if (k_q == PW'(TAPS - 1)) state_d = DRAIN;
      end
      DRAIN: begin
        // k_q restarts at 0 here and counts the two flush cycles.
        if (k_q == PW'(1)) begin
          k_d     = '0;
          state_d = DONE;
        end else begin
          k_d = k_q + PW'(1);
        end
      end
      DONE: begin
        out_valid_d = 1'b1;
        out_data_d  = OW'(round_sat(64'(acc_q), SHIFT, OW));
        wr_ptr_d    = wr_ptr_q + PW'(1);
        state_d     = IDLE;
      end
      default: state_d = CLEAR;
    endcase
  end

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// tb/tb_fir_mac_scheduler.sv - directed self-checking bench for fir_mac_scheduler
module tb_fir_mac_scheduler;

  localparam int TAPS = 32;
  localparam int DW   = 8;
  localparam int CW   = 12;
  localparam int OW   = 14;
  localparam int NU   = 4;
`ifdef FIR_SQUARE_EN
  localparam int         IMP_SHIFT = 15;
  localparam logic [7:0] IMP_BYTE  = 8'h00;
`else
  localparam int         IMP_SHIFT = 1;
  localparam logic [7:0] IMP_BYTE  = 8'h81;
`endif
  localparam logic [7:0] ZERO_BYTE = 8'h80;

  function automatic int coef_val(input int n);
    return ((n * 397) % 4096) - 2048;
  endfunction

  function automatic logic [TAPS*CW-1:0] table_coef();
    logic [TAPS*CW-1:0] v;
    for (int n = 0; n < TAPS; n++) v[n*CW +: CW] = CW'(coef_val(n));
    return v;
  endfunction

  function automatic logic [TAPS*CW-1:0] flat_coef(input int c);
    logic [TAPS*CW-1:0] v;
    for (int n = 0; n < TAPS; n++) v[n*CW +: CW] = CW'(c);
    return v;
  endfunction

  function automatic int exp_imp(input int n);
    if (n >= TAPS) return 0;
    return (coef_val(n) + 1) >>> 1;
  endfunction

  localparam logic [TAPS*CW-1:0] COEF_T = table_coef();
  localparam logic [TAPS*CW-1:0] COEF_P = flat_coef(2047);
  localparam logic [TAPS*CW-1:0] COEF_N = flat_coef(-2048);

  logic                   sys_clk = 1'b0;
  logic                   sys_rst = 1'b1;
  logic [NU-1:0]          iv;
  logic [NU-1:0][7:0]     id;
  logic [NU-1:0]          ir;
  logic [NU-1:0]          ov;
  logic [NU-1:0][OW-1:0]  od;

  int passed = 0;
  int total  = 0;
  int pulses [NU];

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    for (int u = 0; u < NU; u++) if (ov[u] === 1'b1) pulses[u]++;
  end

  fir_mac_scheduler #(.TAPS(TAPS), .DW(DW), .CW(CW), .OW(OW), .SHIFT(IMP_SHIFT),
                      .DECIM(1), .COEF(COEF_T)) u_imp (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .in_valid(iv[0]), .in_data(id[0]),
    .in_ready(ir[0]), .out_valid(ov[0]), .out_data(od[0]));

  fir_mac_scheduler #(.TAPS(TAPS), .DW(DW), .CW(CW), .OW(OW), .SHIFT(1),
                      .DECIM(1), .COEF(COEF_P)) u_satp (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .in_valid(iv[1]), .in_data(id[1]),
    .in_ready(ir[1]), .out_valid(ov[1]), .out_data(od[1]));

  fir_mac_scheduler #(.TAPS(TAPS), .DW(DW), .CW(CW), .OW(OW), .SHIFT(1),
                      .DECIM(1), .COEF(COEF_N)) u_satn (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .in_valid(iv[2]), .in_data(id[2]),
    .in_ready(ir[2]), .out_valid(ov[2]), .out_data(od[2]));

  fir_mac_scheduler #(.TAPS(TAPS), .DW(DW), .CW(CW), .OW(OW), .SHIFT(IMP_SHIFT),
                      .DECIM(4), .COEF(COEF_T)) u_dec (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .in_valid(iv[3]), .in_data(id[3]),
    .in_ready(ir[3]), .out_valid(ov[3]), .out_data(od[3]));

  task automatic send(input int u, input logic [7:0] d, input bit runs,
                      input int exp_val, input string tag);
    int t;
    int lat;
    logic [OW-1:0] want;
    want = OW'(exp_val);
    t = 0;
    while (ir[u] !== 1'b1 && t < 200) begin
      @(negedge sys_clk);
      t++;
    end
    total++;
    if (ir[u] !== 1'b1) begin
      $display("FAIL %s ready_wait got %b want 1", tag, ir[u]);
      return;
    end
    passed++;
    id[u] = d;
    iv[u] = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    iv[u] = 1'b0;
    id[u] = ZERO_BYTE;
    total++;
    if (ir[u] !== 1'b0) $display("FAIL %s ready_after_accept got %b want 0", tag, ir[u]);
    else passed++;
    if (!runs) begin
      @(negedge sys_clk);
      total++;
      if (ir[u] !== 1'b1 || ov[u] !== 1'b0)
        $display("FAIL %s nonrun ready/valid got %b/%b want 1/0", tag, ir[u], ov[u]);
      else passed++;
      return;
    end
    lat = 0;
    while (ov[u] !== 1'b1 && lat < 80) begin
      @(negedge sys_clk);
      lat++;
    end
    total++;
    if (lat !== 36) $display("FAIL %s latency got %0d want 36", tag, lat);
    else passed++;
    total++;
    if (od[u] !== want)
      $display("FAIL %s out_data got %0d want %0d", tag, $signed(od[u]), exp_val);
    else passed++;
  endtask

  task automatic test_reset();
    int zeros;
    int ovbad;
    sys_rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    total++;
    if (ir !== '0 || ov !== '0 || od[0] !== '0)
      $display("FAIL reset_values ready/valid/data got %b/%b/%0d want 0/0/0", ir, ov, od[0]);
    else passed++;
    sys_rst = 1'b0;
    zeros = 0;
    ovbad = 0;
    while (ir[0] !== 1'b1 && zeros < 40) begin
      if (ov !== '0) ovbad++;
      @(negedge sys_clk);
      zeros++;
    end
    total++;
    if (zeros !== 32) $display("FAIL clear_cycles got %0d want 32", zeros);
    else passed++;
    total++;
    if (ovbad !== 0 || od[0] !== '0)
      $display("FAIL clear_outputs got valid_count=%0d data=%0d want 0/0", ovbad, od[0]);
    else passed++;
    total++;
    if (ir !== 4'b1111) $display("FAIL all_ready_after_clear got %b want 1111", ir);
    else passed++;
  endtask

  task automatic test_impulse();
    for (int n = 0; n < TAPS + 2; n++) begin
      send(0, (n == 0) ? IMP_BYTE : ZERO_BYTE, 1'b1, exp_imp(n), $sformatf("impulse[%0d]", n));
      if (n == 0) begin
        repeat (5) @(negedge sys_clk);
        total++;
        if (od[0] !== OW'(exp_imp(0)) || ov[0] !== 1'b0)
          $display("FAIL hold_out got %0d/%b want %0d/0", $signed(od[0]), ov[0], exp_imp(0));
        else passed++;
      end
    end
  endtask

  task automatic test_saturation();
    logic [7:0] seq [4];
    seq = '{8'hFF, 8'hFF, 8'hFF, 8'h00};
    for (int i = 0; i < 4; i++) send(1, seq[i], 1'b1, 8191, $sformatf("sat_pos[%0d]", i));
    for (int i = 0; i < 4; i++) send(2, seq[i], 1'b1, -8192, $sformatf("sat_neg[%0d]", i));
  endtask

  task automatic test_decimation();
    pulses[3] = 0;
    for (int n = 0; n < 8; n++)
      send(3, (n == 0) ? IMP_BYTE : ZERO_BYTE, (n % 4) == 3, exp_imp(n),
           $sformatf("decim[%0d]", n));
    repeat (5) @(negedge sys_clk);
    total++;
    if (pulses[3] !== 2) $display("FAIL decim_pulses got %0d want 2", pulses[3]);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int acc_idx [$];
    int out_idx [$];
    int bad;
    int t;
    t = 0;
    while (ir[0] !== 1'b1 && t < 100) begin
      @(negedge sys_clk);
      t++;
    end
    id[0] = ZERO_BYTE;
    iv[0] = 1'b1;
    for (int i = 0; i < 150; i++) begin
      if (ir[0] === 1'b1) acc_idx.push_back(i);
      if (ov[0] === 1'b1) out_idx.push_back(i);
      @(negedge sys_clk);
    end
    iv[0] = 1'b0;
    total++;
    if (acc_idx.size() !== 5 || out_idx.size() !== 4)
      $display("FAIL b2b_counts got accepts=%0d outs=%0d want 5/4", acc_idx.size(), out_idx.size());
    else passed++;
    bad = 0;
    for (int j = 0; j + 1 < acc_idx.size(); j++)
      if (acc_idx[j+1] - acc_idx[j] != 37) bad++;
    for (int j = 0; j < out_idx.size() && j < acc_idx.size(); j++)
      if (out_idx[j] != acc_idx[j] + 37) bad++;
    total++;
    if (bad !== 0) $display("FAIL b2b_spacing got %0d bad intervals want 0", bad);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int t;
    int zeros;
    int ovbad;
    t = 0;
    while (ir[0] !== 1'b1 && t < 100) begin
      @(negedge sys_clk);
      t++;
    end
    id[0] = IMP_BYTE;
    iv[0] = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    iv[0] = 1'b0;
    repeat (11) @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    total++;
    if (ir[0] !== 1'b0 || ov[0] !== 1'b0 || od[1] !== '0)
      $display("FAIL midreset_values got %b/%b/%0d want 0/0/0", ir[0], ov[0], $signed(od[1]));
    else passed++;
    sys_rst = 1'b0;
    zeros = 0;
    ovbad = 0;
    while (ir[0] !== 1'b1 && zeros < 40) begin
      if (ov[0] !== 1'b0) ovbad++;
      @(negedge sys_clk);
      zeros++;
    end
    total++;
    if (zeros !== 32 || ovbad !== 0)
      $display("FAIL midreset_clear got cycles=%0d valid=%0d want 32/0", zeros, ovbad);
    else passed++;
    send(0, ZERO_BYTE, 1'b1, 0, "post_reset");
  endtask

  initial begin
    iv = '0;
    id = {NU{ZERO_BYTE}};
    for (int u = 0; u < NU; u++) pulses[u] = 0;
    test_reset();
    test_impulse();
    test_saturation();
    test_decimation();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
